mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the pipelined CPU's split instruction and data buses; the other end of the i_*/d_* request interface.
- Holds one shared word-addressed array and serves an instruction port and a data port independently.
- Each port has its own fixed-latency FSM and returns a one-cycle ready pulse.
- Lets the CPU's stall and hazard logic be exercised against realistic multi-cycle memory.

Parameters:
- WORD_SIZE, 16, data/address width in bits.
- ADDR_BITS, 8, index bits; memory depth = 2**ADDR_BITS words.
- LATENCY, 2, clock edges from request acceptance to ready rise (legal range 1..15).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_read  in  1  instruction-port read request.
- i_write  in  1  instruction-port write request (program load).
- i_address  in  WORD_SIZE  instruction-port word address.
- i_data  inout  WORD_SIZE  instruction data; driven by CPU on write, by block on read response.
- i_ready  out  1  one-cycle completion pulse, instruction port.
- d_read  in  1  data-port read request.
- d_write  in  1  data-port write request.
- d_address  in  WORD_SIZE  data-port word address.
- d_data  inout  WORD_SIZE  data bus, same drive rules as i_data.
- d_ready  out  1  one-cycle completion pulse, data port.

Behaviour:
- Reset is asynchronous: while reset=1, both FSMs are IDLE, i_ready=d_ready=0, both data buses are high-Z, and any pending write is discarded.
- Array contents are not reset; they are zero-initialised at time 0 only.
- Per-port FSM has three states: IDLE, WAIT, DONE.
  - IDLE: if read or write is high at edge E0, latch op, address low ADDR_BITS (upper bits ignored, so addresses wrap), and write data from the bus. Load counter with LATENCY-1, then go to WAIT, or straight to DONE if LATENCY=1.
  - WAIT: counter decrements each edge; at the edge where it is 0, go to DONE.
  - DONE: ready=1 for exactly this cycle; at the next edge, return to IDLE.
- Ready therefore rises immediately after edge E0+LATENCY.
- Write commit: the array is updated at edge E0+LATENCY (the edge that raises ready).
- Read: data is fetched from the array at edge E0+LATENCY and driven onto the bus only while in DONE with a read op; the bus is high-Z at all other times.
- Request inputs are ignored in WAIT and DONE. The earliest next acceptance is edge E0+LATENCY+2, giving a throughput of one access per LATENCY+2 cycles per port.
- A request deasserted mid-transaction does not abort it; the transaction completes and ready still pulses.
- read and write both high in IDLE: treated as a write.
- Cross-port, same index, same commit edge:
  - d write plus i write: the d-port value wins.
  - One port reads while the other writes: the read returns the newly written value (write-first).
- Ports are fully independent; there is no arbitration stall between them.
- Reset asserted mid-WAIT: the FSM returns to IDLE, the write is not committed, and no ready pulse occurs.

Decomposition:
- Shared package/include holds WORD_SIZE, the FSM state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2) and the counter width.
- One sub-module, mem_port_fsm, instantiated twice.
  - Handles accept/latch, the latency counter, the ready pulse, and the commit/fetch strobes.
  - Outputs commit_en, commit_idx, commit_data and rd_idx to the top level.
- Top level owns the array, applies write priority and write-first read bypass, and drives the tristate buses.

Test Plan:
- LATENCY=2: d_write=1, d_address=0x0010, d_data=0x1234 at edge 0 → d_ready high only in the cycle after edge 2. Then d_read of 0x0010 accepted at edge 4 → d_data=0x1234 and d_ready=1 in the cycle after edge 6; bus high-Z otherwise.
- Simultaneous commits: d_write 0xAAAA and i_write 0x5555 to index 0x05 at the same edge → subsequent i_read of 0x05 returns 0xAAAA.
- Write-first bypass: i_read of 0x07 and d_write 0xBEEF to 0x07 accepted at the same edge → i_data=0xBEEF in the i_ready cycle.
- Address wrap: d_write 0x0F0F to 0x0103, then d_read of 0x0003 → returns 0x0F0F.
- Reset mid-WAIT: d_write 0x9999 to 0x20 (previously 0x0000); assert reset one cycle after acceptance → no d_ready pulse, d_data high-Z; after release, d_read of 0x20 returns 0x0000.
- Request dropped early: d_read pulsed for 1 cycle with LATENCY=3 → d_ready still pulses exactly once, 3 edges later. A request held high through DONE is not re-accepted until edge E0+5.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared constants for the split instruction/data memory responder:
// default sizing, latency counter width and the per-port FSM encoding.
package mem_responder_pkg;
   localparam int WORD_SIZE = 16;
   localparam int ADDR_BITS = 8;
   localparam int LATENCY   = 2;

   // Wide enough to hold LATENCY-1 for any LATENCY in 1..15
   localparam int CNT_W = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/mem_responder_port_fsm.sv
// One memory port: accepts a request, counts out the fixed latency, pulses ready
// and raises the commit/fetch strobe on the edge that completes the access.
module mem_port_fsm #(
   parameter int WORD_SIZE = mem_responder_pkg::WORD_SIZE,
   parameter int ADDR_BITS = mem_responder_pkg::ADDR_BITS,
   parameter int LATENCY   = mem_responder_pkg::LATENCY
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 read_i,
   input  logic                 write_i,
   input  logic [WORD_SIZE-1:0] addr_i,
   input  logic [WORD_SIZE-1:0] wdata_i,
   output logic                 ready_o,
   output logic                 rd_drive_o,
   output logic                 commit_en_o,
   output logic                 fetch_en_o,
   output logic [ADDR_BITS-1:0] commit_idx_o,
   output logic [WORD_SIZE-1:0] commit_data_o,
   output logic [ADDR_BITS-1:0] rd_idx_o
);
   import mem_responder_pkg::CNT_W;
   import mem_responder_pkg::ST_IDLE;
   import mem_responder_pkg::ST_WAIT;
   import mem_responder_pkg::ST_DONE;

   logic [1:0]           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 wr_q, wr_d;
   logic [ADDR_BITS-1:0] idx_q, idx_d;
   logic [WORD_SIZE-1:0] wdata_q, wdata_d;
   logic                 last_edge;

   // Upper address bits are dropped so addresses wrap onto the array
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr_i[WORD_SIZE-1:ADDR_BITS];

   // Every request passes through WAIT, so ready always follows edge E0+LATENCY
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (read_i || write_i) begin
               state_d = ST_WAIT;
               cnt_d   = CNT_W'(LATENCY - 1);
               wr_d    = write_i;
               idx_d   = addr_i[ADDR_BITS-1:0];
               wdata_d = wdata_i;
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) state_d = ST_DONE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
      end
   end

   assign last_edge     = (state_q == ST_WAIT) && (cnt_q == '0);
   assign commit_en_o   = last_edge && wr_q;
   assign fetch_en_o    = last_edge && !wr_q;
   assign ready_o       = (state_q == ST_DONE);
   assign rd_drive_o    = (state_q == ST_DONE) && !wr_q;
   assign commit_idx_o  = idx_q;
   assign commit_data_o = wdata_q;
   assign rd_idx_o      = idx_q;
endmodule

// File: rtl/mem_responder.sv
// Shared word array behind independent instruction and data ports; same-edge
// writes resolve d-over-i and reads see a write committing on the same edge.
module mem_responder #(
   parameter int WORD_SIZE = mem_responder_pkg::WORD_SIZE,
   parameter int ADDR_BITS = mem_responder_pkg::ADDR_BITS,
   parameter int LATENCY   = mem_responder_pkg::LATENCY
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_read,
   input  logic                 i_write,
   input  logic [WORD_SIZE-1:0] i_address,
   inout  wire  [WORD_SIZE-1:0] i_data,
   output logic                 i_ready,
   input  logic                 d_read,
   input  logic                 d_write,
   input  logic [WORD_SIZE-1:0] d_address,
   inout  wire  [WORD_SIZE-1:0] d_data,
   output logic                 d_ready
);
   localparam int DEPTH = 1 << ADDR_BITS;

   logic [WORD_SIZE-1:0] mem_q [DEPTH];

   logic                 i_drive, i_commit_en, i_fetch_en;
   logic [ADDR_BITS-1:0] i_commit_idx, i_rd_idx;
   logic [WORD_SIZE-1:0] i_commit_data, i_rdata_q, i_rdata_d;
   logic                 d_drive, d_commit_en, d_fetch_en;
   logic [ADDR_BITS-1:0] d_commit_idx, d_rd_idx;
   logic [WORD_SIZE-1:0] d_commit_data, d_rdata_q, d_rdata_d;

   mem_port_fsm #(.WORD_SIZE(WORD_SIZE), .ADDR_BITS(ADDR_BITS), .LATENCY(LATENCY)) u_i_port (
      .clk_i(clk), .rst_i(reset), .read_i(i_read), .write_i(i_write),
      .addr_i(i_address), .wdata_i(i_data), .ready_o(i_ready), .rd_drive_o(i_drive),
      .commit_en_o(i_commit_en), .fetch_en_o(i_fetch_en), .commit_idx_o(i_commit_idx),
      .commit_data_o(i_commit_data), .rd_idx_o(i_rd_idx)
   );

   mem_port_fsm #(.WORD_SIZE(WORD_SIZE), .ADDR_BITS(ADDR_BITS), .LATENCY(LATENCY)) u_d_port (
      .clk_i(clk), .rst_i(reset), .read_i(d_read), .write_i(d_write),
      .addr_i(d_address), .wdata_i(d_data), .ready_o(d_ready), .rd_drive_o(d_drive),
      .commit_en_o(d_commit_en), .fetch_en_o(d_fetch_en), .commit_idx_o(d_commit_idx),
      .commit_data_o(d_commit_data), .rd_idx_o(d_rd_idx)
   );

   // d-port write is applied last so it wins a same-index collision
   always_ff @(posedge clk) begin
      if (i_commit_en) mem_q[i_commit_idx] <= i_commit_data;
      if (d_commit_en) mem_q[d_commit_idx] <= d_commit_data;
   end

   always_comb begin
      i_rdata_d = mem_q[i_rd_idx];
      if (i_commit_en && (i_commit_idx == i_rd_idx)) i_rdata_d = i_commit_data;
      if (d_commit_en && (d_commit_idx == i_rd_idx)) i_rdata_d = d_commit_data;
      d_rdata_d = mem_q[d_rd_idx];
      if (i_commit_en && (i_commit_idx == d_rd_idx)) d_rdata_d = i_commit_data;
      if (d_commit_en && (d_commit_idx == d_rd_idx)) d_rdata_d = d_commit_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         if (i_fetch_en) i_rdata_q <= i_rdata_d;
         if (d_fetch_en) d_rdata_q <= d_rdata_d;
      end
   end

   assign i_data = i_drive ? i_rdata_q : {WORD_SIZE{1'bz}};
   assign d_data = d_drive ? d_rdata_q : {WORD_SIZE{1'bz}};
endmodule
